// File: rtl/gpu_pkg.sv
// Shared graphics definitions: frame geometry, pixel/coordinate types and
// the line rasterizer state encoding.
package gpu_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int FB_DEPTH = H_RES * V_RES;

  localparam int COORD_W  = 10;
  localparam int ADDR_W   = $clog2(FB_DEPTH);
  localparam int PIX_W    = 8;
  // Signed error/delta width: one extra bit for sign, one for 2*err headroom
  localparam int ERR_W    = COORD_W + 2;

  typedef logic [COORD_W-1:0]       coord_t;
  typedef logic [PIX_W-1:0]         pixel_t;
  typedef logic [ADDR_W-1:0]        fb_addr_t;
  typedef logic signed [ERR_W-1:0]  err_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    FINISH
  } rast_state_t;

  // |a - b| widened into the signed error domain
  function automatic err_t abs_diff(input coord_t a, input coord_t b);
    coord_t d;
    d = (a > b) ? (a - b) : (b - a);
    return err_t'({2'b00, d});
  endfunction

endpackage

// File: rtl/line_rasterizer_if.sv
// Command/status and frame-buffer write port bundle for the line rasterizer.
interface line_rasterizer_if;
  import gpu_pkg::*;

  logic     start;
  coord_t   x0;
  coord_t   y0;
  coord_t   x1;
  coord_t   y1;
  pixel_t   color;
  logic     busy;
  logic     done;
  logic     fb_we;
  fb_addr_t fb_addr;
  pixel_t   fb_data;

  // Command source: issues lines, observes status and the write stream
  modport master (
    output start, x0, y0, x1, y1, color,
    input  busy, done, fb_we, fb_addr, fb_data
  );

  // Rasterizer side
  modport slave (
    input  start, x0, y0, x1, y1, color,
    output busy, done, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/fb_addr_calc.sv
// Pure combinational (x,y) -> y*H_RES + x mapping, built as a constant
// shift-add over the set bits of H_RES (320 -> (y<<8) + (y<<6) + x).
module fb_addr_calc
  import gpu_pkg::*;
(
  input  coord_t   x,
  input  coord_t   y,
  output fb_addr_t addr
);

  // Sum y shifted by each set bit position of the row stride, plus x
  always_comb begin
    addr = fb_addr_t'(x);
    for (int unsigned i = 0; i < 32'(ADDR_W); i++) begin
      if (H_RES[i]) begin
        addr = addr + (fb_addr_t'(y) << i);
      end
    end
  end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line engine: takes one (x0,y0)->(x1,y1) command with a colour and
// emits one frame-buffer write per clock, clipping off-screen steps.
module line_rasterizer
  import gpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  line_rasterizer_if.slave bus
);

  rast_state_t state;

  coord_t   x0_q, y0_q, x1_q, y1_q;
  pixel_t   color_q;
  coord_t   cur_x, cur_y;
  err_t     dx, dy, err;
  logic     sx_neg, sy_neg;

  logic     busy_q;
  logic     done_q;
  logic     we_q;
  fb_addr_t addr_q;
  pixel_t   data_q;

  err_t     e2;
  logic     step_x, step_y;
  logic     in_range;
  logic     at_end;
  fb_addr_t cur_addr;

  fb_addr_calc u_addr_calc (
    .x    (cur_x),
    .y    (cur_y),
    .addr (cur_addr)
  );

  // Step decision and clipping for the current pixel; both axis tests share e2
  always_comb begin
    e2       = err <<< 1;
    step_x   = (e2 >= dy);
    step_y   = (e2 <= dx);
    in_range = (cur_x < coord_t'(H_RES)) && (cur_y < coord_t'(V_RES));
    at_end   = (cur_x == x1_q) && (cur_y == y1_q);
  end

  // Control FSM with registered status and frame-buffer outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      dx      <= '0;
      dy      <= '0;
      err     <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            x0_q    <= bus.x0;
            y0_q    <= bus.y0;
            x1_q    <= bus.x1;
            y1_q    <= bus.y1;
            color_q <= bus.color;
            state   <= SETUP;
          end
        end
        SETUP: begin
          dx     <= abs_diff(x1_q, x0_q);
          dy     <= -abs_diff(y1_q, y0_q);
          err    <= abs_diff(x1_q, x0_q) - abs_diff(y1_q, y0_q);
          sx_neg <= !(x0_q < x1_q);
          sy_neg <= !(y0_q < y1_q);
          cur_x  <= x0_q;
          cur_y  <= y0_q;
          data_q <= color_q;
          busy_q <= 1'b1;
          state  <= DRAW;
        end
        DRAW: begin
          // Clipped steps still take a cycle but leave the address untouched
          we_q <= in_range;
          if (in_range) begin
            addr_q <= cur_addr;
          end
          if (at_end) begin
            state <= FINISH;
          end else begin
            if (step_x) begin
              cur_x <= sx_neg ? (cur_x - 1'b1) : (cur_x + 1'b1);
            end
            if (step_y) begin
              cur_y <= sy_neg ? (cur_y - 1'b1) : (cur_y + 1'b1);
            end
            err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
          end
        end
        FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fb_we   = we_q;
  assign bus.fb_addr = addr_q;
  assign bus.fb_data = data_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer driving a modelled 320x240 frame buffer.
module tb_line_rasterizer;

  logic clk;
  logic rst;

  line_rasterizer_if bus ();

  line_rasterizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:76799];

  int wq[$];
  int busy_n;
  int done_e;
  int done_addr;
  int data_bad;
  int oob;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 76800; i++) mem[i] = 8'h00;
  endtask

  function automatic int nonzero_cells();
    int n;
    n = 0;
    for (int i = 0; i < 76800; i++) if (mem[i] != 8'h00) n++;
    return n;
  endfunction

  // Issue one line, then watch the write stream until done or the cycle limit.
  // kick_t > 0 re-pulses start with unrelated coordinates that many cycles later.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int col, input int kick_t, input int limit);
    wq.delete();
    busy_n    = 0;
    done_e    = -1;
    done_addr = -1;
    data_bad  = 0;
    oob       = 0;
    @(negedge clk);
    bus.x0    = 10'(ax0);
    bus.y0    = 10'(ay0);
    bus.x1    = 10'(ax1);
    bus.y1    = 10'(ay1);
    bus.color = 8'(col);
    bus.start = 1'b1;
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      if (t == 1) bus.start = 1'b0;
      if (kick_t > 0 && t == kick_t) begin
        bus.x0    = 10'd100;
        bus.y0    = 10'd100;
        bus.x1    = 10'd0;
        bus.y1    = 10'd0;
        bus.color = 8'h11;
        bus.start = 1'b1;
      end else if (kick_t > 0 && t == kick_t + 1) begin
        bus.start = 1'b0;
      end
      if (bus.fb_we) begin
        wq.push_back(int'(bus.fb_addr));
        if (bus.fb_data !== 8'(col)) data_bad++;
        if (int'(bus.fb_addr) >= 76800) oob++;
        else mem[bus.fb_addr] = bus.fb_data;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_e    = t - 1;
        done_addr = int'(bus.fb_addr);
        break;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int nw;
    int s5_x [11];
    int seen;

    s5_x = '{10, 10, 10, 11, 11, 11, 11, 11, 12, 12, 12};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x0    = '0;
    bus.y0    = '0;
    bus.x1    = '0;
    bus.y1    = '0;
    bus.color = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(bus.busy),    0);
    check("rst_done",    32'(bus.done),    0);
    check("rst_fb_we",   32'(bus.fb_we),   0);
    check("rst_fb_addr", 32'(bus.fb_addr), 0);
    check("rst_fb_data", 32'(bus.fb_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: full top row, left to right
    run_line(0, 0, 319, 0, 'hFF, 0, 400);
    check("s1_writes", wq.size(), 320);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] != i) bad++;
    check("s1_addr_seq_bad", bad, 0);
    check("s1_done_edge", done_e, 322);
    check("s1_data_bad", data_bad, 0);
    check("s1_mem0", 32'(mem[0]), 'hFF);
    check("s1_mem319", 32'(mem[319]), 'hFF);
    check("s1_mem320", 32'(mem[320]), 0);
    check("s1_nonzero", nonzero_cells(), 320);
    clear_mem();

    // 2: degenerate single-point line
    run_line(5, 5, 5, 5, 'h3C, 0, 20);
    check("s2_writes", wq.size(), 1);
    check("s2_addr", (wq.size() > 0) ? wq[0] : -1, 1605);
    check("s2_busy_cycles", busy_n, 2);
    check("s2_done_edge", done_e, 3);
    check("s2_mem", 32'(mem[1605]), 'h3C);
    check("s2_nonzero", nonzero_cells(), 1);
    @(negedge clk);
    check("s2_done_one_cycle", 32'(bus.done), 0);
    clear_mem();

    // 3: full diagonal, bottom-right to top-left
    run_line(319, 239, 0, 0, 'hFF, 0, 400);
    check("s3_writes", wq.size(), 320);
    check("s3_first", (wq.size() > 0) ? wq[0] : -1, 76799);
    check("s3_last", (wq.size() > 0) ? wq[wq.size()-1] : -1, 0);
    bad = 0;
    for (int i = 1; i < wq.size(); i++) begin
      if ((wq[i-1] / 320) - (wq[i] / 320) > 1 || (wq[i-1] / 320) < (wq[i] / 320)) bad++;
      if ((wq[i-1] % 320) - (wq[i] % 320) != 1) bad++;
    end
    check("s3_step_bad", bad, 0);
    check("s3_done_edge", done_e, 322);
    check("s3_nonzero", nonzero_cells(), 320);
    clear_mem();

    // 4: line running off the right edge
    run_line(310, 0, 330, 0, 'hAA, 0, 60);
    check("s4_writes", wq.size(), 10);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] != 310 + i) bad++;
    check("s4_addr_seq_bad", bad, 0);
    check("s4_oob", oob, 0);
    check("s4_done_edge", done_e, 23);
    check("s4_addr_held", done_addr, 319);
    check("s4_nonzero", nonzero_cells(), 10);
    clear_mem();

    // 5: steep line with an ignored second start 3 cycles later
    run_line(10, 10, 12, 20, 'h5A, 3, 60);
    check("s5_writes", wq.size(), 11);
    bad = 0;
    for (int i = 0; i < wq.size() && i < 11; i++)
      if (wq[i] != (10 + i) * 320 + s5_x[i]) bad++;
    check("s5_pixel_bad", bad, 0);
    check("s5_done_edge", done_e, 13);
    check("s5_data_bad", data_bad, 0);
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.busy || bus.fb_we || bus.done) seen++;
    end
    check("s5_no_second_line", seen, 0);
    clear_mem();

    // 6: reset in the middle of a line, then a normal line
    @(negedge clk);
    bus.x0    = 10'd0;
    bus.y0    = 10'd0;
    bus.x1    = 10'd100;
    bus.y1    = 10'd50;
    bus.color = 8'h77;
    bus.start = 1'b1;
    nw = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 1) bus.start = 1'b0;
      if (bus.fb_we) nw++;
      if (nw == 5) break;
    end
    check("s6_reached_5th_write", nw, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_we_after_rst", 32'(bus.fb_we), 0);
    check("s6_busy_after_rst", 32'(bus.busy), 0);
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.done || bus.fb_we) seen++;
    end
    check("s6_no_done_after_abort", seen, 0);
    clear_mem();
    run_line(2, 3, 6, 3, 'h55, 0, 40);
    check("s6_new_writes", wq.size(), 5);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] != 962 + i) bad++;
    check("s6_new_addr_bad", bad, 0);
    check("s6_new_done_edge", done_e, 7);
    check("s6_new_mem", 32'(mem[964]), 'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
